avalon_len_limiter: RTL and testbench
=====================================

# avalon_len_limiter

Packet-length limiter placed directly downstream of `avalon_enforcer`. It consumes the framing-clean `trusted_msg` stream and forwards it unchanged, except for packets longer than `MAX_BEATS` beats. Such a packet is cut at beat `MAX_BEATS`: a forced `eop` is emitted on that beat and the rest of the input packet is discarded. The block also keeps packet and truncation statistics for the control side.

## Interface

Parameters:
- `MAX_BEATS`, default 64: maximum number of output beats per packet. Must be ≥ 1.
- `CNT_WIDTH`, default 16: width of the statistics counters.

Ports:
- `clk`  input  1  single clock. All state updates on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_msg`  `avalon_st_if.slave`  interface  input stream (`data`, `valid`, `rdy`, `sop`, `eop`, `empty`). It comes from the enforcer, so every packet starts with `sop` and there are no nested `sop`s.
- `out_msg`  `avalon_st_if.master`  interface  output stream. Same widths as `in_msg`.
- `packet_truncated`  output  1  one-cycle pulse, raised once per truncated packet.
- `packet_count`  output  `CNT_WIDTH`  number of packets completed on the output, including truncated ones. Wraps to 0.
- `truncated_count`  output  `CNT_WIDTH`  number of truncated packets. Wraps to 0.

## Operation

- Input accept: `acc_in = in_msg.valid & in_msg.rdy`.
- Output accept: `acc_out = out_msg.valid & out_msg.rdy`.
- FSM state `PASS`:
  - `in_msg.rdy = out_msg.rdy`.
  - `out_msg` mirrors `in_msg` field by field.
  - Beat counter `beat_cnt`, width `$clog2(MAX_BEATS+1)`, holds the number of beats already forwarded in the current packet.
  - On `acc_in` with `sop`: `beat_cnt` ← 1.
  - On `acc_in` without `sop`: `beat_cnt` ← `beat_cnt`+1.
  - On `acc_in` with `eop`: `beat_cnt` ← 0.
- Truncation condition: the beat is the `MAX_BEATS`-th beat of the packet, and `in_msg.eop` = 0.
  - The beat number is 1 if `sop` is set, otherwise `beat_cnt`+1.
  - On that beat, `out_msg.eop` is forced to 1 and `out_msg.empty` is forced to 0. `data` passes through.
  - On `acc_in` of that beat: next state `DROP`, `beat_cnt` ← 0, and a truncation is registered.
- FSM state `DROP`:
  - `in_msg.rdy` = 1, so the upstream drains at full rate.
  - `out_msg.valid` = 0. `out_msg.sop`, `eop`, `empty` and `data` are driven to 0.
  - Every input beat is discarded, including any `sop` beat.
  - On `acc_in` with `in_msg.eop` = 1: next state `PASS`.
- Single-beat packets (`sop` & `eop`) always pass untouched, for any `MAX_BEATS` ≥ 1.
- A packet of exactly `MAX_BEATS` beats whose last beat carries `eop` is not truncated.
- `MAX_BEATS` = 1: every multi-beat packet is reduced to its `sop` beat with a forced `eop`.
- Statistics:
  - `packet_count` increments on `acc_out` with `out_msg.eop` = 1. Forced `eop` counts.
  - `truncated_count` increments on the truncating `acc_in`.
  - Both counters wrap modulo 2^`CNT_WIDTH`.

## Timing

- Data path is combinational, with zero latency from `in_msg` to `out_msg`. No data is stored.
- Backpressure:
  - In `PASS`, `out_msg.rdy` low holds the input. No beat is dropped or duplicated.
  - In `DROP`, `out_msg.rdy` is ignored.
- `packet_truncated` is registered. It is high for exactly one cycle, the cycle after the truncating `acc_in`.
- Counters update on the edge that ends the accepting cycle. The new value is visible in the next cycle.
- Reset values: state = `PASS`, `beat_cnt` = 0, `packet_truncated` = 0, `packet_count` = 0, `truncated_count` = 0.
- Reset in the middle of a packet: the block returns to `PASS`. Beats arriving after reset are forwarded as they arrive, counted from 0.
- Reset on the same cycle as a truncating beat: reset wins. No pulse is raised and no counter increments.

## Structure

- Shared package `len_limiter_pack`:
  - `typedef enum logic {PASS, DROP} len_sm_t`.
  - Default constants `MAX_BEATS_DEF` = 64 and `CNT_WIDTH_DEF` = 16.
- Single module, with no sub-module. FSM, beat counter and statistics live in one `always_ff`. Output muxing lives in one `always_comb`.

## Test plan

- `MAX_BEATS` = 4, 3-beat packet (`sop`, -, `eop`), `rdy` = 1 → identical 3 beats out; `packet_count` = 1, `truncated_count` = 0, no pulse.
- `MAX_BEATS` = 4, 7-beat packet with `empty` = 2 on the last beat → 4 beats out; beat 4 has `eop` = 1 and `empty` = 0. Input beats 5–7 are accepted with `out_msg.valid` = 0. `packet_truncated` is high one cycle after beat 4. Both counters = 1.
- `MAX_BEATS` = 4, exactly 4-beat packet ending in `eop` → passes unchanged; `truncated_count` = 0.
- `MAX_BEATS` = 4, 7-beat packet with `out_msg.rdy` toggling 1/0 every cycle → output beats identical to the previous case. `in_msg.rdy` is 1 throughout `DROP`.
- Truncated packet immediately followed by a 1-beat `sop`&`eop` packet → the 1-beat packet is dropped only if it arrives before the long packet's `eop`; otherwise it passes. `packet_count` = 2 in the pass case.
- `rst` asserted on a cycle when the block is in `DROP` → next cycle state is `PASS`, all counters 0. The next input beat is forwarded.

Source files
------------

// File: rtl/avalon_len_limiter_pkg.sv
// Shared types and default constants for the packet-length limiter.
package len_limiter_pack;

  typedef enum logic {PASS, DROP} len_sm_t;

  localparam int MAX_BEATS_DEF = 64;
  localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/avalon_len_limiter_if.sv
// Avalon-ST style packet stream with sop/eop/empty framing.
interface avalon_st_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);

  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               rdy;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);

endinterface

// File: rtl/avalon_len_limiter.sv
// Forwards a framed stream unchanged, cutting packets longer than MAX_BEATS
// with a forced eop and discarding the remainder; keeps packet statistics.
module avalon_len_limiter
  import len_limiter_pack::*;
#(
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_st_if.slave           in_msg,
  avalon_st_if.master          out_msg,
  output logic                 packet_truncated,
  output logic [CNT_WIDTH-1:0] packet_count,
  output logic [CNT_WIDTH-1:0] truncated_count
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_B = CW'(MAX_BEATS);

  len_sm_t              state_q, state_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                 trunc_q, trunc_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] trc_cnt_q, trc_cnt_d;

  logic [CW-1:0] beat_num;
  logic          at_limit;
  logic          in_rdy;
  logic          o_valid;
  logic          o_eop;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    trc_cnt_d  = trc_cnt_q;

    // Position of the presented beat within its packet, counting from 1.
    beat_num = in_msg.sop ? CW'(1) : beat_cnt_q + CW'(1);
    at_limit = (beat_num == MAX_B) && !in_msg.eop;

    in_rdy        = out_msg.rdy;
    o_valid       = in_msg.valid;
    o_eop         = in_msg.eop;
    out_msg.sop   = in_msg.sop;
    out_msg.data  = in_msg.data;
    out_msg.empty = in_msg.empty;

    case (state_q)
      PASS: begin
        if (at_limit) begin
          o_eop         = 1'b1;
          out_msg.empty = '0;
        end
        if (in_msg.valid && in_rdy) begin
          if (at_limit) begin
            state_d    = DROP;
            beat_cnt_d = '0;
            trunc_d    = 1'b1;
            trc_cnt_d  = trc_cnt_q + CNT_WIDTH'(1);
          end else if (in_msg.eop) begin
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_num;
          end
        end
        if (o_valid && out_msg.rdy && o_eop) begin
          pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
        end
      end
      DROP: begin
        // Drain the rest of the oversize packet at full rate, output idle.
        in_rdy        = 1'b1;
        o_valid       = 1'b0;
        o_eop         = 1'b0;
        out_msg.sop   = 1'b0;
        out_msg.data  = '0;
        out_msg.empty = '0;
        if (in_msg.valid && in_msg.eop) begin
          state_d = PASS;
        end
      end
      default: begin
        state_d = PASS;
      end
    endcase

    in_msg.rdy    = in_rdy;
    out_msg.valid = o_valid;
    out_msg.eop   = o_eop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PASS;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
      pkt_cnt_q  <= '0;
      trc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
      pkt_cnt_q  <= pkt_cnt_d;
      trc_cnt_q  <= trc_cnt_d;
    end
  end

  assign packet_truncated = trunc_q;
  assign packet_count     = pkt_cnt_q;
  assign truncated_count  = trc_cnt_q;

endmodule

// File: tb/tb_avalon_len_limiter.sv
// Directed bench for avalon_len_limiter with MAX_BEATS = 4.
module tb_avalon_len_limiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        packet_truncated;
  logic [15:0] packet_count;
  logic [15:0] truncated_count;
  int          nvec = 0;
  int          nerr = 0;

  avalon_st_if #(.DATA_W(16), .EMPTY_W(2)) in_if ();
  avalon_st_if #(.DATA_W(16), .EMPTY_W(2)) out_if ();

  avalon_len_limiter #(.MAX_BEATS(4), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_msg           (in_if.slave),
    .out_msg          (out_if.master),
    .packet_truncated (packet_truncated),
    .packet_count     (packet_count),
    .truncated_count  (truncated_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [1:0] emp, input logic [15:0] d, input logic ordy);
    in_if.valid  = v;
    in_if.sop    = s;
    in_if.eop    = e;
    in_if.empty  = emp;
    in_if.data   = d;
    out_if.rdy   = ordy;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nvec++; if (packet_truncated !== 1'b0) begin nerr++; $display("FAIL reset_pulse got %b want 0", packet_truncated); end
    nvec++; if (packet_count !== 16'd0) begin nerr++; $display("FAIL reset_pkt_cnt got %0d want 0", packet_count); end
    nvec++; if (truncated_count !== 16'd0) begin nerr++; $display("FAIL reset_trc_cnt got %0d want 0", truncated_count); end
    nvec++; if (out_if.valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", out_if.valid); end
  endtask

  task automatic test_short;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i == 1, i == 3, 2'd0, 16'(16'hB000 + i), 1'b1);
      nvec++; if (out_if.valid !== 1'b1 || out_if.sop !== (i == 1) || out_if.eop !== (i == 3))
        begin nerr++; $display("FAIL short_ctrl beat %0d got v%b s%b e%b", i, out_if.valid, out_if.sop, out_if.eop); end
      nvec++; if (out_if.data !== 16'(16'hB000 + i)) begin nerr++; $display("FAIL short_data beat %0d got %h want %h", i, out_if.data, 16'(16'hB000 + i)); end
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nvec++; if (packet_count !== 16'd1) begin nerr++; $display("FAIL short_pkt_cnt got %0d want 1", packet_count); end
    nvec++; if (truncated_count !== 16'd0) begin nerr++; $display("FAIL short_trc_cnt got %0d want 0", truncated_count); end
    nvec++; if (packet_truncated !== 1'b0) begin nerr++; $display("FAIL short_pulse got %b want 0", packet_truncated); end
  endtask

  task automatic test_trunc;
    logic ev;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, i == 1, i == 7, (i == 7) ? 2'd2 : 2'd0, 16'(16'hA000 + i), 1'b1);
      ev = (i <= 4);
      nvec++; if (in_if.rdy !== 1'b1) begin nerr++; $display("FAIL trunc_in_rdy beat %0d got %b want 1", i, in_if.rdy); end
      nvec++; if (out_if.valid !== ev) begin nerr++; $display("FAIL trunc_valid beat %0d got %b want %b", i, out_if.valid, ev); end
      if (ev) begin
        nvec++; if (out_if.eop !== (i == 4) || out_if.empty !== 2'd0 || out_if.data !== 16'(16'hA000 + i))
          begin nerr++; $display("FAIL trunc_beat %0d got e%b m%0d d%h", i, out_if.eop, out_if.empty, out_if.data); end
      end else begin
        nvec++; if (out_if.data !== 16'h0 || out_if.eop !== 1'b0) begin nerr++; $display("FAIL trunc_drop_out beat %0d got d%h e%b want 0", i, out_if.data, out_if.eop); end
      end
      if (i == 5) begin
        nvec++; if (packet_truncated !== 1'b1) begin nerr++; $display("FAIL trunc_pulse_hi got %b want 1", packet_truncated); end
      end
      if (i == 6) begin
        nvec++; if (packet_truncated !== 1'b0) begin nerr++; $display("FAIL trunc_pulse_lo got %b want 0", packet_truncated); end
      end
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nvec++; if (packet_count !== 16'd1) begin nerr++; $display("FAIL trunc_pkt_cnt got %0d want 1", packet_count); end
    nvec++; if (truncated_count !== 16'd1) begin nerr++; $display("FAIL trunc_trc_cnt got %0d want 1", truncated_count); end
  endtask

  task automatic test_exact;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i == 1, i == 4, (i == 4) ? 2'd1 : 2'd0, 16'(16'hC000 + i), 1'b1);
      nvec++; if (out_if.valid !== 1'b1 || out_if.eop !== (i == 4) || out_if.empty !== ((i == 4) ? 2'd1 : 2'd0))
        begin nerr++; $display("FAIL exact_beat %0d got v%b e%b m%0d", i, out_if.valid, out_if.eop, out_if.empty); end
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nvec++; if (packet_truncated !== 1'b0) begin nerr++; $display("FAIL exact_pulse got %b want 0", packet_truncated); end
    nvec++; if (truncated_count !== 16'd0) begin nerr++; $display("FAIL exact_trc_cnt got %0d want 0", truncated_count); end
    nvec++; if (packet_count !== 16'd1) begin nerr++; $display("FAIL exact_pkt_cnt got %0d want 1", packet_count); end
  endtask

  task automatic test_backpressure;
    int   i;
    int   cyc;
    logic ordy;
    logic exp_acc;
    do_reset();
    i   = 1;
    cyc = 0;
    while (i <= 7 && cyc < 60) begin
      ordy = (cyc % 2 == 0);
      drive(1'b1, i == 1, i == 7, (i == 7) ? 2'd2 : 2'd0, 16'(16'hD000 + i), ordy);
      exp_acc = (i <= 4) ? ordy : 1'b1;
      nvec++; if (in_if.rdy !== exp_acc) begin nerr++; $display("FAIL bp_in_rdy beat %0d cyc %0d got %b want %b", i, cyc, in_if.rdy, exp_acc); end
      nvec++; if (out_if.valid !== (i <= 4)) begin nerr++; $display("FAIL bp_valid beat %0d got %b want %b", i, out_if.valid, (i <= 4)); end
      if (i <= 4) begin
        nvec++; if (out_if.eop !== (i == 4) || out_if.data !== 16'(16'hD000 + i))
          begin nerr++; $display("FAIL bp_beat %0d got e%b d%h", i, out_if.eop, out_if.data); end
      end
      step();
      if (exp_acc) i++;
      cyc++;
    end
    nvec++; if (i <= 7) begin nerr++; $display("FAIL bp_timeout stuck at beat %0d want 8", i); end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nvec++; if (packet_count !== 16'd1 || truncated_count !== 16'd1)
      begin nerr++; $display("FAIL bp_counts got %0d/%0d want 1/1", packet_count, truncated_count); end
  endtask

  task automatic test_after_trunc;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, i == 1, i == 7, 2'd0, 16'(16'hE000 + i), 1'b1);
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 2'd3, 16'hE0F0, 1'b1);
    nvec++; if (out_if.valid !== 1'b1 || out_if.sop !== 1'b1 || out_if.eop !== 1'b1 || out_if.empty !== 2'd3)
      begin nerr++; $display("FAIL after_single_pass got v%b s%b e%b m%0d", out_if.valid, out_if.sop, out_if.eop, out_if.empty); end
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nvec++; if (packet_count !== 16'd2) begin nerr++; $display("FAIL after_pkt_cnt got %0d want 2", packet_count); end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i == 1, 1'b0, 2'd0, 16'(16'hE100 + i), 1'b1);
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 2'd0, 16'hE1F0, 1'b1);
    nvec++; if (out_if.valid !== 1'b0 || in_if.rdy !== 1'b1)
      begin nerr++; $display("FAIL after_single_drop got v%b r%b want v0 r1", out_if.valid, in_if.rdy); end
    step();
    drive(1'b1, 1'b1, 1'b1, 2'd0, 16'hE2F0, 1'b1);
    nvec++; if (out_if.valid !== 1'b1 || out_if.data !== 16'hE2F0)
      begin nerr++; $display("FAIL after_next_pass got v%b d%h want v1 dE2F0", out_if.valid, out_if.data); end
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nvec++; if (packet_count !== 16'd4 || truncated_count !== 16'd2)
      begin nerr++; $display("FAIL after_counts got %0d/%0d want 4/2", packet_count, truncated_count); end
  endtask

  task automatic test_reset_in_drop;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, i == 1, 1'b0, 2'd0, 16'(16'hF000 + i), 1'b1);
      step();
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nvec++; if (packet_count !== 16'd0 || truncated_count !== 16'd0 || packet_truncated !== 1'b0)
      begin nerr++; $display("FAIL rdrop_state got %0d/%0d/%b want 0/0/0", packet_count, truncated_count, packet_truncated); end
    // Continuation beats after reset count from zero: the 4th one is cut.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd1, 16'(16'hF100 + i), 1'b1);
      nvec++; if (out_if.valid !== 1'b1 || out_if.data !== 16'(16'hF100 + i) || out_if.eop !== (i == 4))
        begin nerr++; $display("FAIL rdrop_fwd beat %0d got v%b d%h e%b", i, out_if.valid, out_if.data, out_if.eop); end
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    nvec++; if (truncated_count !== 16'd1) begin nerr++; $display("FAIL rdrop_trc_cnt got %0d want 1", truncated_count); end
  endtask

  task automatic test_reset_on_trunc;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, i == 1, 1'b0, 2'd0, 16'(16'h9000 + i), 1'b1);
      step();
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h9004, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'd0, 16'h9100, 1'b1);
    nvec++; if (packet_truncated !== 1'b0 || truncated_count !== 16'd0 || packet_count !== 16'd0)
      begin nerr++; $display("FAIL rtrunc_state got %b/%0d/%0d want 0/0/0", packet_truncated, truncated_count, packet_count); end
    nvec++; if (out_if.valid !== 1'b1 || out_if.eop !== 1'b0)
      begin nerr++; $display("FAIL rtrunc_fwd got v%b e%b want v1 e0", out_if.valid, out_if.eop); end
    step();
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    step();
    test_reset();
    test_short();
    test_trunc();
    test_exact();
    test_backpressure();
    test_after_trunc();
    test_reset_in_drop();
    test_reset_on_trunc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
